rr_resource_scheduler: RTL and testbench
========================================

Name: rr_resource_scheduler

Overview:
Grant-holding round-robin scheduler that shares one resource (bus, memory port, datapath) among NUM_REQ requesters. It builds on the team's 4-way round-robin arbiter by keeping a grant until the owner signals completion, and by bounding how long one owner may hold the resource. It also inserts a one-cycle dead gap between owners so that driver handover is contention-free. It sits between the requesting masters and the shared resource's mux/enable logic.

Parameters:
NUM_REQ, 4, number of requesters (2..16).
HOLD_MAX, 16, maximum consecutive GRANT cycles per owner before a forced release (>=2).
ID_W, $clog2(NUM_REQ), width of the owner index.
CNT_W, $clog2(HOLD_MAX+1), width of the hold counter.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
req_i  input  NUM_REQ  per-requester request level; held high while the requester wants the resource.
done_i  input  NUM_REQ  per-requester single-cycle completion pulse; only the owner's bit is honoured.
gnt_o  output  NUM_REQ  registered one-hot grant; all zero when no owner.
gnt_id_o  output  ID_W  registered index of the current owner; valid only while busy_o=1.
busy_o  output  1  registered; high while in GRANT.
timeout_o  output  1  registered one-cycle pulse when an owner is force-released by HOLD_MAX.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, gnt_o=0, gnt_id_o=0, busy_o=0, timeout_o=0, hold_cnt=0, ptr=0 (requester 0 has highest priority first). A reset mid-grant drops gnt_o in the same cycle, without waiting for a clock edge.
- FSM states: IDLE, GRANT, GAP.
- Arbitration (IDLE or GAP): if req_i!=0, pick the first set bit scanning ptr, ptr+1, ... NUM_REQ-1, 0, ... with wrap. On the next edge: gnt_o=onehot(pick), gnt_id_o=pick, busy_o=1, hold_cnt=0, state=GRANT. If req_i==0, go to or stay in IDLE.
- Latency: a request sampled at edge k on an idle scheduler produces gnt_o visible after edge k, i.e. in the very next cycle.
- GRANT: hold_cnt increments each cycle. Release occurs at the edge where any of these holds:
  (a) done_i[owner]=1,
  (b) req_i[owner]=0,
  (c) hold_cnt==HOLD_MAX-1.
  On release: gnt_o=0, busy_o=0, ptr=(owner+1) mod NUM_REQ, state=GAP.
- Maximum hold: an owner is granted for at most HOLD_MAX cycles.
- timeout_o=1 for exactly one cycle (the first GAP cycle) only when release is due to (c) alone. If (a) or (b) coincides with (c), timeout_o stays 0.
- GAP: exactly one cycle with gnt_o=0. It arbitrates as IDLE does, using the updated ptr. Back-to-back owners are therefore separated by exactly one zero-grant cycle.
- done_i from non-owners is ignored in every state. done_i in IDLE/GAP is ignored.
- A requester dropping req_i while not owner simply loses eligibility; no state is kept per requester.
- Fairness: with all requests held high continuously, grants rotate 0,1,2,3,0,... Each owner waits at most (NUM_REQ-1)*(HOLD_MAX+1) cycles.
- gnt_o is always one-hot or zero. gnt_o!=0 if and only if busy_o=1.

Decomposition:
- Package rr_sched_pkg:
  - state enum (IDLE, GRANT, GAP),
  - default NUM_REQ/HOLD_MAX localparams,
  - function wrap_inc(idx, n).
- Sub-module rr_pick: purely combinational rotate-priority picker. Inputs req[NUM_REQ] and ptr[ID_W]; outputs valid and idx[ID_W]. It is verified standalone and instantiated once.
- The FSM, counter and output registers live in the top level.

Test Plan:
- Reset then req_i=4'b0000 for 5 cycles -> gnt_o=0000, busy_o=0 throughout. Assert reset mid-grant -> gnt_o=0000 immediately, without waiting for a clock edge.
- req_i=4'b1111 held, done_i pulsed by each owner after 3 GRANT cycles -> gnt_o sequence 0001,0010,0100,1000,0001. Each grant lasts 3 cycles and is followed by one 0000 gap cycle.
- req_i=4'b0100 held, no done_i, HOLD_MAX=16 -> gnt_o=0100 for exactly 16 cycles, then one 0000 cycle with timeout_o=1, then gnt_o=0100 again.
- Owner 1 granted with req_i=4'b1010, then done_i=4'b1000 (non-owner) -> ignored, gnt_o stays 0010. Owner drops req_i[1] -> gap cycle, then gnt_o=1000.
- Owner 2 at hold_cnt=HOLD_MAX-1 with done_i[2]=1 in the same cycle -> released, timeout_o stays 0, next search starts at index 3.
- req_i=4'b1001 with ptr=1 after an owner-0 grant -> next grant is 1000 (wrap scan 1,2,3), then 0001.

Source files
------------

// File: rtl/rr_sched_pkg.sv
// Shared types, defaults and index helpers for the grant-holding round-robin scheduler.
package rr_sched_pkg;

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_HOLD_MAX = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Next requester index after idx, wrapping at n.
  function automatic int wrap_inc(input int idx, input int n);
    return ((idx + 1) >= n) ? 0 : (idx + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set request scanning ptr, ptr+1, ... with wrap.
module rr_pick
  import rr_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               valid,
  output logic [ID_W-1:0]    idx
);

  int   cand_s;
  logic hit_s;

  // Scan from ptr; the first hit latches the index and masks later candidates.
  always_comb begin
    valid  = 1'b0;
    idx    = {ID_W{1'b0}};
    cand_s = 0;
    hit_s  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s = int'(ptr) + i;
      cand_s = (cand_s >= NUM_REQ) ? (cand_s - NUM_REQ) : cand_s;
      hit_s  = ~valid & req[cand_s];
      idx    = hit_s ? ID_W'(cand_s) : idx;
      valid  = valid | hit_s;
    end
  end

endmodule

// File: rtl/rr_resource_scheduler.sv
// Grant-holding round-robin scheduler with bounded hold time and a one-cycle
// dead gap between successive owners.
module rr_resource_scheduler
  import rr_sched_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int HOLD_MAX = DEF_HOLD_MAX,
  parameter int ID_W     = $clog2(NUM_REQ),
  parameter int CNT_W    = $clog2(HOLD_MAX + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] done_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_id_o,
  output logic               busy_o,
  output logic               timeout_o
);

  state_t             state_r, state_n_s;
  logic [ID_W-1:0]    ptr_r, ptr_n_s;
  logic [CNT_W-1:0]   hold_cnt_r, hold_n_s;
  logic [NUM_REQ-1:0] gnt_n_s;
  logic [ID_W-1:0]    id_n_s;
  logic               busy_n_s, timeout_n_s;

  logic               pick_valid_s;
  logic [ID_W-1:0]    pick_idx_s;
  logic               owner_done_s, owner_req_s, hold_last_s, release_s;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req   (req_i),
    .ptr   (ptr_r),
    .valid (pick_valid_s),
    .idx   (pick_idx_s)
  );

  assign owner_done_s = done_i[gnt_id_o];
  assign owner_req_s  = req_i[gnt_id_o];
  assign hold_last_s  = (hold_cnt_r == CNT_W'(HOLD_MAX - 1));
  assign release_s    = owner_done_s | ~owner_req_s | hold_last_s;

  // Next-state and next-output logic; timeout flags only a purely time-forced release.
  always_comb begin
    state_n_s   = state_r;
    ptr_n_s     = ptr_r;
    hold_n_s    = hold_cnt_r;
    gnt_n_s     = gnt_o;
    id_n_s      = gnt_id_o;
    busy_n_s    = busy_o;
    timeout_n_s = 1'b0;
    case (state_r)
      IDLE, GAP: begin
        if (pick_valid_s) begin
          state_n_s = GRANT;
          gnt_n_s   = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
          id_n_s    = pick_idx_s;
          busy_n_s  = 1'b1;
          hold_n_s  = {CNT_W{1'b0}};
        end else begin
          state_n_s = IDLE;
          gnt_n_s   = {NUM_REQ{1'b0}};
          busy_n_s  = 1'b0;
        end
      end
      GRANT: begin
        if (release_s) begin
          state_n_s   = GAP;
          gnt_n_s     = {NUM_REQ{1'b0}};
          busy_n_s    = 1'b0;
          ptr_n_s     = ID_W'(wrap_inc(int'(gnt_id_o), NUM_REQ));
          timeout_n_s = hold_last_s & ~owner_done_s & owner_req_s;
        end else begin
          hold_n_s = hold_cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_n_s = IDLE;
        gnt_n_s   = {NUM_REQ{1'b0}};
        busy_n_s  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      ptr_r      <= {ID_W{1'b0}};
      hold_cnt_r <= {CNT_W{1'b0}};
      gnt_o      <= {NUM_REQ{1'b0}};
      gnt_id_o   <= {ID_W{1'b0}};
      busy_o     <= 1'b0;
      timeout_o  <= 1'b0;
    end else begin
      state_r    <= state_n_s;
      ptr_r      <= ptr_n_s;
      hold_cnt_r <= hold_n_s;
      gnt_o      <= gnt_n_s;
      gnt_id_o   <= id_n_s;
      busy_o     <= busy_n_s;
      timeout_o  <= timeout_n_s;
    end
  end

endmodule

// File: tb/tb_rr_resource_scheduler.sv
// Directed bench for rr_resource_scheduler (NUM_REQ=4, HOLD_MAX=16) with hand-computed expectations.
module tb_rr_resource_scheduler;

  logic       clk;
  logic       reset;
  logic [3:0] req_i;
  logic [3:0] done_i;
  logic [3:0] gnt_o;
  logic [1:0] gnt_id_o;
  logic       busy_o;
  logic       timeout_o;

  int n_cmp = 0;
  int n_bad = 0;

  rr_resource_scheduler #(
    .NUM_REQ  (4),
    .HOLD_MAX (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req_i),
    .done_i    (done_i),
    .gnt_o     (gnt_o),
    .gnt_id_o  (gnt_id_o),
    .busy_o    (busy_o),
    .timeout_o (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Grant-cycle check: one-hot grant, owner id, busy, no timeout.
  task automatic check_grant(input string tag, input logic [3:0] g, input logic [1:0] id);
    check({tag, "_gnt"}, gnt_o, g);
    check({tag, "_id"}, gnt_id_o, id);
    check({tag, "_busy"}, busy_o, 1'b1);
    check({tag, "_to"}, timeout_o, 1'b0);
  endtask

  task automatic check_gap(input string tag, input logic to);
    check({tag, "_gnt"}, gnt_o, 4'b0000);
    check({tag, "_busy"}, busy_o, 1'b0);
    check({tag, "_to"}, timeout_o, to);
  endtask

  logic [3:0] exp_seq [5];
  logic [1:0] exp_id  [5];

  initial begin
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    reset  = 1'b1;
    req_i  = 4'b0000;
    done_i = 4'b0000;
    #1;
    check_gap("rst", 1'b0);
    check("rst_id", gnt_id_o, 2'd0);
    tick();
    reset = 1'b0;

    // Idle: no requests
    for (int i = 0; i < 5; i++) begin
      tick();
      check_gap("idle", 1'b0);
    end

    // All requesting, each owner completes after 3 grant cycles
    req_i = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      check_grant("rot_c1", exp_seq[k], exp_id[k]);
      tick();
      check_grant("rot_c2", exp_seq[k], exp_id[k]);
      tick();
      check_grant("rot_c3", exp_seq[k], exp_id[k]);
      done_i = exp_seq[k];
      tick();
      done_i = 4'b0000;
      check_gap("rot_gap", 1'b0);
      if (k == 4) req_i = 4'b0000;
      tick();
    end
    check_gap("rot_idle", 1'b0);   // ptr is now 1

    // Single requester 2 with no done: forced release after 16 cycles
    req_i = 4'b0100;
    tick();
    for (int i = 0; i < 16; i++) begin
      check_grant("hold", 4'b0100, 2'd2);
      tick();
    end
    check_gap("hold_gap", 1'b1);
    tick();
    check_grant("hold_regrant", 4'b0100, 2'd2);
    req_i = 4'b0000;
    tick();
    check_gap("drop_gap", 1'b0);
    tick();
    check_gap("drop_idle", 1'b0);  // ptr is now 3

    // Wrap scan: owner 0 first, then req 1001 from ptr=1 gives 3 then 0
    req_i = 4'b0001;
    tick();
    check_grant("wrap_o0", 4'b0001, 2'd0);
    req_i  = 4'b1001;
    done_i = 4'b0001;
    tick();
    done_i = 4'b0000;
    check_gap("wrap_gap0", 1'b0);
    tick();
    check_grant("wrap_o3", 4'b1000, 2'd3);
    done_i = 4'b1000;
    tick();
    done_i = 4'b0000;
    check_gap("wrap_gap3", 1'b0);
    tick();
    check_grant("wrap_o0b", 4'b0001, 2'd0);
    req_i = 4'b0000;
    tick();
    check_gap("wrap_gap0b", 1'b0);
    tick();                          // ptr is now 1

    // Non-owner done ignored; owner 1 drops request
    req_i = 4'b1010;
    tick();
    check_grant("nodone_o1", 4'b0010, 2'd1);
    done_i = 4'b1000;
    tick();
    done_i = 4'b0000;
    check_grant("nodone_hold", 4'b0010, 2'd1);
    req_i = 4'b1000;
    tick();
    check_gap("nodone_gap", 1'b0);
    tick();
    check_grant("nodone_o3", 4'b1000, 2'd3);
    req_i = 4'b0000;
    tick();
    tick();
    check_gap("nodone_idle", 1'b0);  // ptr is now 0

    // Owner 2 done coincides with hold limit: no timeout, next search from 3
    req_i = 4'b0100;
    tick();
    check_grant("coinc_c1", 4'b0100, 2'd2);
    for (int i = 1; i < 16; i++) tick();
    check_grant("coinc_c16", 4'b0100, 2'd2);
    done_i = 4'b0100;
    req_i  = 4'b1111;
    tick();
    done_i = 4'b0000;
    check_gap("coinc_gap", 1'b0);
    tick();
    check_grant("coinc_next", 4'b1000, 2'd3);

    // Asynchronous reset mid-grant
    #2;
    reset = 1'b1;
    #1;
    check("arst_gnt", gnt_o, 4'b0000);
    check("arst_busy", busy_o, 1'b0);
    check("arst_id", gnt_id_o, 2'd0);
    req_i = 4'b0000;
    tick();
    reset = 1'b0;
    tick();
    check_gap("arst_idle", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
